// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory read feeding a 2-entry {pc, word} buffer.
// Redirects flush the buffer; a read still in flight at redirect time is drained in DROP.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk1,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);
  localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};
  localparam logic [1:0]  FULL   = 2'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  state_t            r_state;
  logic              r_boot;
  logic [31:0]       r_pc;
  logic              r_mem_req;
  logic [31:0]       r_mem_addr;
  logic [1:0]        r_count;
  logic              r_rd;
  logic              r_wr;
  logic [1:0][31:0]  r_fpc;
  logic [1:0][31:0]  r_word;

  logic              w_pop;
  logic              w_push;
  logic [1:0]        w_occ_pop;
  logic              w_room_after_push;
  logic [31:0]       w_tgt;
  logic [31:0]       w_pc_inc;
  logic              w_unused;

  assign instr_valid       = (r_count != 2'd0);
  assign instr             = r_word[r_rd];
  assign instr_pc          = r_fpc[r_rd];
  assign mem_req           = r_mem_req;
  assign mem_addr          = r_mem_addr;

  // A redirect wins over both the pop and the push of the same cycle.
  assign w_pop             = instr_valid & instr_ready & ~branch_valid;
  assign w_push            = (r_state == S_REQ) & mem_ack & ~branch_valid;
  assign w_occ_pop         = r_count - {1'b0, w_pop};
  assign w_room_after_push = (w_occ_pop + 2'd1) < FULL;
  assign w_tgt             = {branch_target[31:2], 2'b00};
  assign w_pc_inc          = r_pc + 32'd4;
  assign w_unused          = ^branch_target[1:0];

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_boot     <= 1'b0;
      r_pc       <= RST_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RST_PC;
      r_count    <= 2'd0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_fpc      <= '0;
      r_word     <= '0;
    end else begin
      // r_boot holds off the first request by one cycle after reset release.
      r_boot <= 1'b1;
      if (branch_valid) begin
        r_count <= 2'd0;
        r_rd    <= 1'b0;
        r_wr    <= 1'b0;
      end else begin
        if (w_push) begin
          r_fpc[r_wr]  <= r_pc;
          r_word[r_wr] <= mem_rdata;
          r_wr         <= ~r_wr;
        end
        if (w_pop) r_rd <= ~r_rd;
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end

      case (r_state)
        S_IDLE: begin
          if (branch_valid) begin
            r_state    <= S_REQ;
            r_pc       <= w_tgt;
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_tgt;
          end else if (r_boot && (w_occ_pop < FULL)) begin
            r_state    <= S_REQ;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_pc;
          end
        end
        S_REQ: begin
          if (branch_valid) begin
            r_pc <= w_tgt;
            if (mem_ack) r_mem_addr <= w_tgt;
            else         r_state    <= S_DROP;
          end else if (mem_ack) begin
            r_pc       <= w_pc_inc;
            r_mem_addr <= w_pc_inc;
            if (!w_room_after_push) begin
              r_state   <= S_IDLE;
              r_mem_req <= 1'b0;
            end
          end
        end
        S_DROP: begin
          // Address stays on the stale request until it is acked; r_pc tracks the latest target.
          if (branch_valid) r_pc <= w_tgt;
          if (mem_ack) begin
            r_state    <= S_REQ;
            r_mem_addr <= branch_valid ? w_tgt : r_pc;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of expected {pc} entries, word derived from a memory model.
module tb_fetch_unit;
  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bv;
  logic [31:0] bt;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        rdy;

  int          n_total = 0;
  int          n_fail  = 0;
  logic [31:0] sb[$];

  always #5 clk1 = ~clk1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign mem_rdata = mem_ack ? memf(mem_addr) : 32'hBAD0_BAD0;

  fetch_unit dut (
    .clk1         (clk1),
    .rst_n        (rst_n),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .branch_valid (bv),
    .branch_target(bt),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (rdy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Sample on the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk1);
    if (bv) sb.delete();
    else if (instr_valid && rdy) begin
      chkb("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pop_pc", instr_pc, e);
        chk("pop_word", instr, memf(e));
      end
    end
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chkb("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chkb("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    sb.delete();
    bv = 1'b0; bt = '0; mem_ack = 1'b0; rdy = 1'b0;
    repeat (2) begin @(posedge clk1); #1; end
    rst_n = 1'b1;
  endtask

  task automatic start(input logic a, input logic r);
    do_reset();
    mem_ack = a;
    rdy     = r;
    tick();
    chkb("boot_no_req", mem_req, 1'b0);
    tick();
    chkb("first_req", mem_req, 1'b1);
    chk("first_addr", mem_addr, 32'h0);
  endtask

  initial begin
    rst_n = 1'b1; mem_ack = 1'b0; rdy = 1'b0; bv = 1'b0; bt = '0;
    #2;

    // Streaming: ack and ready tied high.
    start(1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      chkb("a_req", mem_req, 1'b1);
      chk("a_addr", mem_addr, 32'(4 * k));
      chkb("a_valid", instr_valid, k > 0);
      if (k > 0) chk("a_trail_pc", instr_pc, 32'(4 * (k - 1)));
      sb.push_back(32'(4 * k));
      tick();
    end
    chkb("a_midreq", mem_req, 1'b1);

    // Decoder stalled: buffer fills to two, then requests stop.
    start(1'b1, 1'b0);
    sb.push_back(32'h0);
    tick();
    chkb("b_req4", mem_req, 1'b1);
    chk("b_addr4", mem_addr, 32'h4);
    sb.push_back(32'h4);
    tick();
    chkb("b_full_noreq", mem_req, 1'b0);
    chkb("b_valid", instr_valid, 1'b1);
    chk("b_head", instr_pc, 32'h0);
    tick();
    chkb("b_full_noreq2", mem_req, 1'b0);
    chk("b_head2", instr_pc, 32'h0);
    rdy = 1'b1;
    tick();
    chk("b_head_next", instr_pc, 32'h4);
    chkb("b_req8", mem_req, 1'b1);
    chk("b_addr8", mem_addr, 32'h8);
    sb.push_back(32'h8);
    tick();

    // Slow memory: ack arrives after three idle cycles.
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chkb("c_hold_req", mem_req, 1'b1);
      chk("c_hold_addr", mem_addr, 32'hC);
      tick();
    end
    mem_ack = 1'b1;
    chk("c_ack_addr", mem_addr, 32'hC);
    sb.push_back(32'hC);
    tick();
    mem_ack = 1'b0;
    chkb("c_valid", instr_valid, 1'b1);
    chk("c_pc", instr_pc, 32'hC);
    tick();
    chkb("c_single_push", instr_valid, 1'b0);
    chk("c_next_addr", mem_addr, 32'h10);

    // Redirect with a read in flight: stale word drained and dropped.
    bv = 1'b1; bt = 32'h0000_0103;
    tick();
    bv = 1'b0;
    chkb("d_drop_req", mem_req, 1'b1);
    chk("d_drop_addr", mem_addr, 32'h10);
    chkb("d_drop_valid", instr_valid, 1'b0);
    tick();
    chk("d_drop_hold", mem_addr, 32'h10);
    mem_ack = 1'b1;
    tick();
    chk("d_tgt_addr", mem_addr, 32'h100);
    chkb("d_no_stale", instr_valid, 1'b0);
    sb.push_back(32'h100);
    tick();
    mem_ack = 1'b0;
    chkb("d_valid", instr_valid, 1'b1);
    chk("d_pc", instr_pc, 32'h100);
    tick();
    chk("d_addr104", mem_addr, 32'h104);
    chkb("d_empty", instr_valid, 1'b0);

    // Second redirect while already draining retargets the PC.
    bv = 1'b1; bt = 32'h200;
    tick();
    chk("dd_addr", mem_addr, 32'h104);
    bt = 32'h302;
    tick();
    chk("dd_addr2", mem_addr, 32'h104);
    bv = 1'b0; mem_ack = 1'b1;
    tick();
    chk("dd_tgt", mem_addr, 32'h300);
    chkb("dd_valid", instr_valid, 1'b0);

    // Redirect coinciding with an ack and a pop.
    sb.push_back(32'h300);
    tick();
    chkb("e_valid", instr_valid, 1'b1);
    chk("e_pc", instr_pc, 32'h300);
    bv = 1'b1; bt = 32'h40;
    tick();
    bv = 1'b0; mem_ack = 1'b0;
    chkb("e_flushed", instr_valid, 1'b0);
    chkb("e_req", mem_req, 1'b1);
    chk("e_addr", mem_addr, 32'h40);

    // Address wrap at the top of memory, then reset mid-request.
    bv = 1'b1; bt = 32'hFFFF_FFFF; mem_ack = 1'b1;
    tick();
    bv = 1'b0;
    chk("f_addr_top", mem_addr, 32'hFFFF_FFFC);
    chkb("f_valid0", instr_valid, 1'b0);
    sb.push_back(32'hFFFF_FFFC);
    tick();
    chk("f_wrap", mem_addr, 32'h0);
    chk("f_pc_top", instr_pc, 32'hFFFF_FFFC);
    chk("f_word_top", instr, memf(32'hFFFF_FFFC));
    sb.push_back(32'h0);
    tick();
    mem_ack = 1'b0;
    chk("f_addr4", mem_addr, 32'h4);
    chk("f_pc0", instr_pc, 32'h0);
    chkb("f_midreq", mem_req, 1'b1);
    do_reset();

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: fetch address loaded at reset; bits[1:0] SHALL be treated as zero.
REQ-002 Parameter DEPTH, default 2: prefetch buffer entries; only the value 2 SHALL be supported.
REQ-003 clk1  input  1  single clock; all state SHALL change on the rising edge only.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 mem_req  output  1  instruction memory read request.
REQ-006 mem_addr  output  32  word-aligned read address, bits[1:0] always 0.
REQ-007 mem_ack  input  1  memory accepts the request and returns data in the same cycle.
REQ-008 mem_rdata  input  32  instruction word, valid only when mem_ack=1.
REQ-009 branch_valid  input  1  one-cycle redirect strobe from execute.
REQ-010 branch_target  input  32  redirect address; bits[1:0] ignored.
REQ-011 instr  output  32  instruction word at the buffer head, fed to the decoder.
REQ-012 instr_pc  output  32  address of instr.
REQ-013 instr_valid  output  1  buffer head holds a valid instruction.
REQ-014 instr_ready  input  1  decoder consumes the head this cycle.

Function
REQ-015 The block SHALL hold a fetch PC, a 2-entry FIFO of {pc, word}, and a control FSM with states IDLE, REQ and DROP.
REQ-016 IDLE -> REQ: the FSM SHALL make this transition when FIFO occupancy after this cycle's pop is < 2 and branch_valid=0.
REQ-017 REQ: mem_req=1 and mem_addr=fetch PC; both SHALL stay stable until mem_ack.
REQ-018 REQ with mem_ack=1 and no branch: the block SHALL push {PC, mem_rdata} and set PC to PC+4, wrapping 32'hFFFFFFFC to 0.
REQ-019 After an ack, the FSM SHALL stay in REQ when the post-push occupancy is < 2; otherwise it SHALL go to IDLE. Back-to-back sustained rate SHALL be 1 word per cycle.
REQ-020 A pop SHALL occur when instr_valid and instr_ready are both 1; a simultaneous push and pop at occupancy 2 SHALL NOT occur, because a request is never issued against a full FIFO.
REQ-021 instr, instr_pc and instr_valid SHALL be driven directly from registers or the head entry; there is no combinational path from mem_rdata to instr.
REQ-022 Fetch-to-decode latency: a word acked in cycle N SHALL appear at instr with instr_valid=1 in cycle N+1.
REQ-023 branch_valid=1 SHALL flush the FIFO, set instr_valid=0 next cycle and load PC={branch_target[31:2],2'b00}; branch SHALL take priority over push and pop in the same cycle.
REQ-024 branch_valid in REQ with mem_ack=0: the FSM SHALL go to DROP, hold mem_req and the old mem_addr until mem_ack, discard that data, then go to REQ at the target.
REQ-025 branch_valid in REQ with mem_ack=1: the acked data SHALL be discarded and the FSM SHALL go to REQ at the target next cycle.
REQ-026 branch_valid in DROP: the block SHALL update PC to the new target and remain in DROP.
REQ-027 branch_valid in IDLE: the FSM SHALL go to REQ at the target next cycle.
REQ-028 In DROP, mem_req SHALL stay 1 until mem_ack; no other request SHALL be outstanding at any time.

Reset
REQ-029 While rst_n=0, the block SHALL force: PC=RESET_PC, FIFO empty, FSM=IDLE, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-030 Reset assertion mid-request SHALL abandon the transaction immediately, with no handshake completion required.
REQ-031 After rst_n deasserts, the first mem_req SHALL rise on the second rising edge of clk1.

Verification
REQ-032 Reset release, mem_ack tied 1, instr_ready tied 1 -> the bench SHALL see mem_addr 0,4,8,... on consecutive cycles and instr_pc trailing mem_addr by 1 cycle.
REQ-033 instr_ready=0 with mem_ack=1 -> the bench SHALL see exactly 2 words buffered (pc 0,4), then mem_req=0; on instr_ready=1 it SHALL see pops in order with instr_pc 0 then 4.
REQ-034 mem_ack delayed 3 cycles -> the bench SHALL see mem_req and mem_addr held constant for all 3 cycles, then a single push.
REQ-035 branch_valid with target 32'h00000103 while a request is pending with no ack -> the bench SHALL see DROP, the stale word never reaching instr, and the next request at 32'h00000100.
REQ-036 branch_valid coincident with mem_ack and a pop -> the bench SHALL see instr_valid=0 next cycle and the next mem_addr equal to the target.
REQ-037 PC at 32'hFFFFFFFC acked -> the bench SHALL see the next mem_addr=0; rst_n pulsed low mid-request -> the bench SHALL see all outputs return to their reset values within the same cycle.
